// File: rtl/tagged_regfile_mp_if.sv
// Dispatch-side bundle of the tagged register file: write-back ports, decode rename,
// operand reads, recovery controls and the busy count.
interface tagged_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NAMEW = 5,
    parameter int TAGW  = 4,
    parameter int NRD   = 2,
    parameter int NWB   = 2
);
    logic [NWB-1:0]       wb_en;
    logic [NWB*NAMEW-1:0] wb_name;
    logic [NWB*XLEN-1:0]  wb_data;
    logic [NWB*TAGW-1:0]  wb_tag;
    logic                 dec_en;
    logic [NAMEW-1:0]     dec_name;
    logic [TAGW-1:0]      dec_tag;
    logic [NRD*NAMEW-1:0] rd_name;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD*TAGW-1:0]  rd_tag;
    logic                 flush;
    logic                 ckpt_save;
    logic                 ckpt_restore;
    logic [NAMEW:0]       busy_cnt;

    modport master (
        output wb_en, wb_name, wb_data, wb_tag,
        output dec_en, dec_name, dec_tag,
        output rd_name, flush, ckpt_save, ckpt_restore,
        input  rd_data, rd_tag, busy_cnt
    );

    modport slave (
        input  wb_en, wb_name, wb_data, wb_tag,
        input  dec_en, dec_name, dec_tag,
        input  rd_name, flush, ckpt_save, ckpt_restore,
        output rd_data, rd_tag, busy_cnt
    );
endinterface

// File: rtl/tagged_regfile_mp.sv
// Multi-port architectural register file with Tomasulo rename tags, CDB forwarding,
// global flush and a single-slot tag-table checkpoint.
module tagged_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NAMEW = 5,
    parameter int TAGW  = 4,
    parameter int NRD   = 2,
    parameter int NWB   = 2
) (
    input logic           clk,
    input logic           rst,
    tagged_regfile_mp_if.slave bus
);
    localparam logic [TAGW-1:0] TAG_FREE = '1;

    logic [XLEN-1:0] data_q   [NREG];
    logic [XLEN-1:0] data_n   [NREG];
    logic [TAGW-1:0] tag_q    [NREG];
    logic [TAGW-1:0] tag_clr  [NREG];
    logic [TAGW-1:0] tag_n    [NREG];
    logic [TAGW-1:0] snap_q   [NREG];
    logic [TAGW-1:0] snap_clr [NREG];
    logic [TAGW-1:0] snap_n   [NREG];
    logic [NAMEW:0]  busy_q;
    logic [NAMEW:0]  busy_n;

    always_comb begin : next_state
        logic [NAMEW-1:0] wn;
        logic [TAGW-1:0]  wt;
        // NOTE: every comb output gets a default before any branch, so no path leaves it unassigned (no latch).
        data_n   = data_q;
        tag_clr  = tag_q;
        snap_clr = snap_q;
        wn       = '0;
        wt       = '0;

        // Ascending port order lets the higher-index port's data win on a name clash.
        for (int i = 0; i < NWB; i++) begin
            wn = bus.wb_name[i*NAMEW +: NAMEW];
            wt = bus.wb_tag[i*TAGW +: TAGW];
            if (bus.wb_en[i] && wn != '0) begin
                data_n[wn] = bus.wb_data[i*XLEN +: XLEN];
                if (tag_q[wn] == wt)  tag_clr[wn]  = TAG_FREE;
                if (snap_q[wn] == wt) snap_clr[wn] = TAG_FREE;
            end
        end

        tag_n  = tag_clr;
        snap_n = snap_clr;
        if (bus.flush) begin
            for (int k = 0; k < NREG; k++) tag_n[k] = TAG_FREE;
            snap_n = snap_q;
        end else if (bus.ckpt_restore) begin
            tag_n = snap_clr;
        end else begin
            if (bus.dec_en && bus.dec_name != '0) tag_n[bus.dec_name] = bus.dec_tag;
            if (bus.ckpt_save) snap_n = tag_n;
        end

        busy_n = '0;
        for (int k = 1; k < NREG; k++) begin
            if (tag_n[k] != TAG_FREE) busy_n = busy_n + {{NAMEW{1'b0}}, 1'b1};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is cleared on reset because software may read any register before writing it.
            for (int k = 0; k < NREG; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= TAG_FREE;
                snap_q[k] <= TAG_FREE;
            end
            busy_q <= '0;
        end else begin
            data_q <= data_n;
            tag_q  <= tag_n;
            snap_q <= snap_n;
            busy_q <= busy_n;
        end
    end

    assign bus.busy_cnt = busy_q;

    // Reads see the pre-edge table; a completing producer is bypassed from the CDB.
    always_comb begin : read_ports
        logic [NAMEW-1:0] rn;
        logic [NAMEW-1:0] wn;
        bus.rd_data = '0;
        bus.rd_tag  = '1;
        rn = '0;
        wn = '0;
        for (int r = 0; r < NRD; r++) begin
            rn = bus.rd_name[r*NAMEW +: NAMEW];
            if (!rst && rn != '0) begin
                bus.rd_data[r*XLEN +: XLEN] = data_q[rn];
                bus.rd_tag[r*TAGW +: TAGW]  = tag_q[rn];
                for (int i = 0; i < NWB; i++) begin
                    wn = bus.wb_name[i*NAMEW +: NAMEW];
                    if (bus.wb_en[i] && wn == rn && tag_q[rn] != TAG_FREE &&
                        bus.wb_tag[i*TAGW +: TAGW] == tag_q[rn]) begin
                        bus.rd_data[r*XLEN +: XLEN] = bus.wb_data[i*XLEN +: XLEN];
                        bus.rd_tag[r*TAGW +: TAGW]  = TAG_FREE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tagged_regfile_mp.sv
// Scoreboard bench for tagged_regfile_mp: directed recovery scenarios then random traffic,
// compared against an array-based reference model.
module tb_tagged_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NAMEW = 5;
    localparam int TAGW  = 4;
    localparam int NRD   = 2;
    localparam int NWB   = 2;
    localparam logic [TAGW-1:0] FREE = '1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tagged_regfile_mp_if #(.XLEN(XLEN), .NAMEW(NAMEW), .TAGW(TAGW), .NRD(NRD), .NWB(NWB)) bus ();

    tagged_regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NAMEW(NAMEW), .TAGW(TAGW), .NRD(NRD), .NWB(NWB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stimulus for the current cycle
    logic             s_rst;
    logic [NWB-1:0]   s_wb_en;
    logic [NAMEW-1:0] s_wb_name [NWB];
    logic [XLEN-1:0]  s_wb_data [NWB];
    logic [TAGW-1:0]  s_wb_tag  [NWB];
    logic             s_dec_en;
    logic [NAMEW-1:0] s_dec_name;
    logic [TAGW-1:0]  s_dec_tag;
    logic [NAMEW-1:0] s_rd_name [NRD];
    logic             s_flush, s_save, s_restore;

    // Reference model: architectural state as plain arrays
    logic [XLEN-1:0] m_data [NREG];
    logic [TAGW-1:0] m_tag  [NREG];
    logic [TAGW-1:0] m_snap [NREG];

    typedef struct packed {
        logic [NRD*XLEN-1:0] data;
        logic [NRD*TAGW-1:0] tag;
        logic [NAMEW:0]      busy;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic clear_stim();
        s_wb_en = '0; s_dec_en = 1'b0; s_dec_name = '0; s_dec_tag = '0;
        s_flush = 1'b0; s_save = 1'b0; s_restore = 1'b0;
        for (int i = 0; i < NWB; i++) begin
            s_wb_name[i] = '0; s_wb_data[i] = '0; s_wb_tag[i] = '0;
        end
        for (int r = 0; r < NRD; r++) s_rd_name[r] = '0;
    endtask

    task automatic drive_inputs();
        rst = s_rst;
        bus.wb_en = s_wb_en;
        for (int i = 0; i < NWB; i++) begin
            bus.wb_name[i*NAMEW +: NAMEW] = s_wb_name[i];
            bus.wb_data[i*XLEN +: XLEN]   = s_wb_data[i];
            bus.wb_tag[i*TAGW +: TAGW]    = s_wb_tag[i];
        end
        bus.dec_en = s_dec_en; bus.dec_name = s_dec_name; bus.dec_tag = s_dec_tag;
        for (int r = 0; r < NRD; r++) bus.rd_name[r*NAMEW +: NAMEW] = s_rd_name[r];
        bus.flush = s_flush; bus.ckpt_save = s_save; bus.ckpt_restore = s_restore;
    endtask

    function automatic int busy_count();
        int b = 0;
        for (int k = 0; k < NREG; k++) if (m_tag[k] != FREE) b++;
        return b;
    endfunction

    // Expected operand for a read: stored state, unless a CDB broadcast completes the pending producer.
    task automatic drive_and_expect();
        exp_t e;
        logic [NAMEW-1:0] n;
        drive_inputs();
        e = '0;
        for (int r = 0; r < NRD; r++) begin
            n = s_rd_name[r];
            e.data[r*XLEN +: XLEN] = '0;
            e.tag[r*TAGW +: TAGW]  = FREE;
            if (!s_rst && n != 0) begin
                e.data[r*XLEN +: XLEN] = m_data[n];
                e.tag[r*TAGW +: TAGW]  = m_tag[n];
                for (int i = 0; i < NWB; i++)
                    if (m_tag[n] != FREE && s_wb_en[i] && s_wb_name[i] == n && s_wb_tag[i] == m_tag[n]) begin
                        e.data[r*XLEN +: XLEN] = s_wb_data[i];
                        e.tag[r*TAGW +: TAGW]  = FREE;
                    end
            end
        end
        e.busy = (NAMEW+1)'(busy_count());
        exp_q.push_back(e);
    endtask

    task automatic model_update();
        logic [TAGW-1:0] nt [NREG];
        logic [TAGW-1:0] ns [NREG];
        if (s_rst) begin
            for (int k = 0; k < NREG; k++) begin
                m_data[k] = '0; m_tag[k] = FREE; m_snap[k] = FREE;
            end
            return;
        end
        nt = m_tag;
        ns = m_snap;
        for (int i = 0; i < NWB; i++) begin
            if (s_wb_en[i] && s_wb_name[i] != 0) begin
                m_data[s_wb_name[i]] = s_wb_data[i];
                if (m_tag[s_wb_name[i]] == s_wb_tag[i])  nt[s_wb_name[i]] = FREE;
                if (m_snap[s_wb_name[i]] == s_wb_tag[i]) ns[s_wb_name[i]] = FREE;
            end
        end
        if (s_flush) begin
            for (int k = 0; k < NREG; k++) m_tag[k] = FREE;
        end else if (s_restore) begin
            m_tag  = ns;
            m_snap = ns;
        end else begin
            if (s_dec_en && s_dec_name != 0) nt[s_dec_name] = s_dec_tag;
            m_tag  = nt;
            m_snap = s_save ? nt : ns;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        drive_and_expect();
        advance();
    endtask

    task automatic look(input string nm, input int port, input logic [XLEN-1:0] d, input logic [TAGW-1:0] t);
        check({nm, "_data"}, 128'(bus.rd_data[port*XLEN +: XLEN]), 128'(d));
        check({nm, "_tag"}, 128'(bus.rd_tag[port*TAGW +: TAGW]), 128'(t));
    endtask

    task automatic look_busy(input string nm, input int b);
        check(nm, 128'(bus.busy_cnt), 128'(b));
    endtask

    task automatic dec(input int name, input int tag);
        clear_stim(); s_dec_en = 1'b1; s_dec_name = NAMEW'(name); s_dec_tag = TAGW'(tag);
        step();
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_rd_data", 128'(bus.rd_data), 128'(e.data));
                check("sb_rd_tag", 128'(bus.rd_tag), 128'(e.tag));
                check("sb_busy_cnt", 128'(bus.busy_cnt), 128'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [NAMEW-1:0] n;
        clear_stim();
        s_rst = 1'b1;
        drive_inputs();
        advance();
        advance();

        // Reads while reset is held
        s_rd_name[0] = 5'd5; s_rd_name[1] = 5'd0;
        drive_and_expect(); #3;
        check("rst_rd_tag", 128'(bus.rd_tag), 128'(8'hFF));
        check("rst_rd_data", 128'(bus.rd_data), 128'(64'h0));
        look_busy("rst_busy", 0);
        advance();

        s_rst = 1'b0;
        drive_and_expect(); #3;
        look("post_rst_r5", 0, 32'h0, FREE);
        look("post_rst_r0", 1, 32'h0, FREE);
        advance();

        // Rename then CDB completion with forwarding
        dec(3, 2);
        clear_stim();
        s_wb_en = 2'b01; s_wb_name[0] = 5'd3; s_wb_tag[0] = 4'd2; s_wb_data[0] = 32'hDEAD_BEEF;
        s_rd_name[0] = 5'd3; s_rd_name[1] = 5'd3;
        drive_and_expect(); #3;
        look("fwd_r3", 0, 32'hDEAD_BEEF, FREE);
        look_busy("fwd_busy_before", 1);
        advance();
        clear_stim(); s_rd_name[0] = 5'd3;
        drive_and_expect(); #3;
        look("stored_r3", 0, 32'hDEAD_BEEF, FREE);
        look_busy("fwd_busy_after", 0);
        advance();

        // Stale producer must not clear a newer rename
        dec(3, 2);
        dec(3, 5);
        clear_stim();
        s_wb_en = 2'b01; s_wb_name[0] = 5'd3; s_wb_tag[0] = 4'd2; s_wb_data[0] = 32'h11;
        s_rd_name[0] = 5'd3;
        drive_and_expect(); #3;
        look("stale_wb_nofwd", 0, 32'hDEAD_BEEF, 4'd5);
        advance();
        clear_stim(); s_rd_name[0] = 5'd3;
        drive_and_expect(); #3;
        look("stale_wb_after", 0, 32'h11, 4'd5);
        advance();

        // Same-cycle rename and completion of the old producer
        dec(7, 10);
        clear_stim();
        s_dec_en = 1'b1; s_dec_name = 5'd7; s_dec_tag = 4'd6;
        s_wb_en = 2'b10; s_wb_name[1] = 5'd7; s_wb_tag[1] = 4'd10; s_wb_data[1] = 32'h22;
        s_rd_name[0] = 5'd7;
        drive_and_expect(); #3;
        look("dec_wb_same_read", 0, 32'h22, FREE);
        advance();
        clear_stim(); s_rd_name[0] = 5'd7;
        drive_and_expect(); #3;
        look("dec_wb_same_after", 0, 32'h22, 4'd6);
        advance();

        // Checkpoint recovery
        clear_stim();
        s_wb_en = 2'b11; s_wb_name[0] = 5'd3; s_wb_tag[0] = 4'd5; s_wb_name[1] = 5'd7; s_wb_tag[1] = 4'd6;
        s_wb_data[0] = 32'h3; s_wb_data[1] = 32'h7;
        step();
        clear_stim(); s_dec_en = 1'b1; s_dec_name = 5'd1; s_dec_tag = 4'd1; s_save = 1'b1;
        step();
        dec(2, 3);
        dec(1, 4);
        clear_stim();
        s_wb_en = 2'b01; s_wb_name[0] = 5'd1; s_wb_tag[0] = 4'd1; s_wb_data[0] = 32'h55;
        step();
        clear_stim(); s_restore = 1'b1; s_rd_name[0] = 5'd1; s_rd_name[1] = 5'd2;
        drive_and_expect(); #3;
        look_busy("pre_restore_busy", 2);
        advance();
        clear_stim(); s_rd_name[0] = 5'd1; s_rd_name[1] = 5'd2;
        drive_and_expect(); #3;
        look("restore_r1", 0, 32'h55, FREE);
        check("restore_r2_tag", 128'(bus.rd_tag[TAGW +: TAGW]), 128'(FREE));
        look_busy("restore_busy", 0);
        advance();

        // Flush with concurrent decode and write-backs
        dec(4, 7);
        dec(9, 8);
        clear_stim();
        s_flush = 1'b1; s_dec_en = 1'b1; s_dec_name = 5'd10; s_dec_tag = 4'd9;
        s_wb_en = 2'b11; s_wb_name[0] = 5'd0; s_wb_data[0] = 32'h44; s_wb_tag[0] = 4'd0;
        s_wb_name[1] = 5'd4; s_wb_data[1] = 32'h33; s_wb_tag[1] = 4'd0;
        step();
        clear_stim(); s_rd_name[0] = 5'd4; s_rd_name[1] = 5'd10;
        drive_and_expect(); #3;
        look("flush_r4", 0, 32'h33, FREE);
        check("flush_r10_tag", 128'(bus.rd_tag[TAGW +: TAGW]), 128'(FREE));
        look_busy("flush_busy", 0);
        advance();
        clear_stim(); s_rd_name[0] = 5'd0; s_rd_name[1] = 5'd9;
        drive_and_expect(); #3;
        look("r0_ignored", 0, 32'h0, FREE);
        check("flush_r9_tag", 128'(bus.rd_tag[TAGW +: TAGW]), 128'(FREE));
        advance();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            clear_stim();
            s_rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NWB; i++) begin
                n = NAMEW'($urandom_range(0, NREG-1));
                s_wb_en[i]   = ($urandom_range(0, 1) == 1);
                s_wb_name[i] = n;
                s_wb_data[i] = $urandom;
                s_wb_tag[i]  = ($urandom_range(0, 3) != 0) ? m_tag[n] : TAGW'($urandom_range(0, 14));
            end
            if (s_wb_en == 2'b11 && s_wb_name[0] == s_wb_name[1] && s_wb_tag[0] == s_wb_tag[1])
                s_wb_en[1] = 1'b0;
            s_dec_en   = ($urandom_range(0, 1) == 1);
            s_dec_name = NAMEW'($urandom_range(0, NREG-1));
            s_dec_tag  = TAGW'($urandom_range(0, 14));
            s_flush    = ($urandom_range(0, 39) == 0);
            s_save     = ($urandom_range(0, 9) == 0);
            s_restore  = ($urandom_range(0, 11) == 0);
            for (int r = 0; r < NRD; r++)
                s_rd_name[r] = ($urandom_range(0, 1) == 1) ? s_wb_name[r % NWB]
                                                           : NAMEW'($urandom_range(0, NREG-1));
            step();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
